// File: rtl/proc_pkg.sv
// Shared definitions for the simple processor: opcodes, ALU codes, control states and IR fields.
package proc_pkg;

    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

    localparam logic [3:0] OP_MV  = 4'b0000;
    localparam logic [3:0] OP_MVI = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;

    localparam int unsigned OP_MSB = 15;
    localparam int unsigned OP_LSB = 12;
    localparam int unsigned RX_MSB = 11;
    localparam int unsigned RX_LSB = 9;
    localparam int unsigned RY_MSB = 8;
    localparam int unsigned RY_LSB = 6;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SRL);
    endfunction

    // ALU opcodes are contiguous from add, so the ALU code is the offset from OP_ADD.
    function automatic logic [2:0] alu_code(input logic [3:0] op);
        logic [3:0] diff;
        diff = op - OP_ADD;
        return diff[2:0];
    endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module dec3to8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_control.sv
// Multicycle control unit: fetches an instruction from DIN and sequences register, bus and ALU
// strobes through states T0..T3.
module proc_control
    import proc_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic              IRin,
    output logic [7:0]        Rin,
    output logic [7:0]        Rout,
    output logic              Gout,
    output logic              DINout,
    output logic              Ain,
    output logic              Gin,
    output logic [2:0]        alu_ctrl,
    output logic              Done
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] ir_q;

    logic [3:0] opcode;
    logic [2:0] rx, ry;
    logic       rin_en, rout_en;
    logic [2:0] rin_sel, rout_sel;
    logic       unused_ir;

    assign opcode    = ir_q[OP_MSB:OP_LSB];
    assign rx        = ir_q[RX_MSB:RX_LSB];
    assign ry        = ir_q[RY_MSB:RY_LSB];
    assign unused_ir = ^ir_q[RY_LSB-1:0];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (IRin) begin
                ir_q <= DIN;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        IRin     = 1'b0;
        rin_en   = 1'b0;
        rin_sel  = rx;
        rout_en  = 1'b0;
        rout_sel = rx;
        Gout     = 1'b0;
        DINout   = 1'b0;
        Ain      = 1'b0;
        Gin      = 1'b0;
        alu_ctrl = ALU_ADD;
        Done     = 1'b0;
        unique case (state_q)
            T0: begin
                if (Run) begin
                    // Gated so that every output stays low while reset is held.
                    IRin    = Resetn;
                    state_d = T1;
                end
            end
            T1: begin
                if (opcode == OP_MV) begin
                    rout_en  = 1'b1;
                    rout_sel = ry;
                    rin_en   = 1'b1;
                    Done     = 1'b1;
                    state_d  = T0;
                end else if (opcode == OP_MVI) begin
                    DINout  = 1'b1;
                    rin_en  = 1'b1;
                    Done    = 1'b1;
                    state_d = T0;
                end else if (is_alu_op(opcode)) begin
                    rout_en = 1'b1;
                    Ain     = 1'b1;
                    state_d = T2;
                end else begin
                    Done    = 1'b1;
                    state_d = T0;
                end
            end
            T2: begin
                rout_en  = 1'b1;
                rout_sel = ry;
                Gin      = 1'b1;
                alu_ctrl = alu_code(opcode);
                state_d  = T3;
            end
            T3: begin
                Gout    = 1'b1;
                rin_en  = 1'b1;
                Done    = 1'b1;
                state_d = T0;
            end
            default: state_d = T0;
        endcase
    end

    dec3to8 u_dec_rin (
        .en  (rin_en),
        .sel (rin_sel),
        .y   (Rin)
    );

    dec3to8 u_dec_rout (
        .en  (rout_en),
        .sel (rout_sel),
        .y   (Rout)
    );

endmodule

// File: tb/tb_proc_control.sv
// Table-driven self-checking bench for proc_control with a scoreboard queue of expected strobes.
module tb_proc_control;

    logic        Clock;
    logic        Resetn;
    logic        Run;
    logic [15:0] DIN;
    logic        IRin;
    logic [7:0]  Rin;
    logic [7:0]  Rout;
    logic        Gout;
    logic        DINout;
    logic        Ain;
    logic        Gin;
    logic [2:0]  alu_ctrl;
    logic        Done;

    proc_control #(.DATA_W(16)) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Run      (Run),
        .DIN      (DIN),
        .IRin     (IRin),
        .Rin      (Rin),
        .Rout     (Rout),
        .Gout     (Gout),
        .DINout   (DINout),
        .Ain      (Ain),
        .Gin      (Gin),
        .alu_ctrl (alu_ctrl),
        .Done     (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct packed {
        logic        run;
        logic [15:0] din;
        logic        irin;
        logic [7:0]  rin;
        logic [7:0]  rout;
        logic        gout;
        logic        dinout;
        logic        ain;
        logic        gin;
        logic [2:0]  alu;
        logic        done;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   done_cycles[$];

    function automatic vec_t mk(input logic run, input logic [15:0] din, input logic irin,
                                input logic [7:0] rin, input logic [7:0] rout, input logic gout,
                                input logic dinout, input logic ain, input logic gin,
                                input logic [2:0] alu, input logic done);
        vec_t v;
        v = '{run, din, irin, rin, rout, gout, dinout, ain, gin, alu, done};
        return v;
    endfunction

    function automatic logic [24:0] outs();
        return {IRin, Rin, Rout, Gout, DINout, Ain, Gin, alu_ctrl, Done};
    endfunction

    task automatic check_invariants(input string name);
        int bus;
        bus = $countones(Rout) + int'(Gout) + int'(DINout);
        checks++;
        if (bus > 1 || !$onehot0(Rin) || !$onehot0(Rout)) begin
            failures++;
            $display("FAIL %s invariant: Rin=%b Rout=%b Gout=%b DINout=%b, required one-hot/zero and one bus driver",
                     name, Rin, Rout, Gout, DINout);
        end
    endtask

    task automatic compare(input string name);
        vec_t        e;
        logic [24:0] want;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e    = exp_q.pop_front();
        want = {e.irin, e.rin, e.rout, e.gout, e.dinout, e.ain, e.gin, e.alu, e.done};
        if (outs() !== want) begin
            failures++;
            $display("FAIL %s: got {IRin,Rin,Rout,Gout,DINout,Ain,Gin,alu,Done}=%b required %b",
                     name, outs(), want);
        end
        check_invariants(name);
    endtask

    // One clock cycle: drive, sample at the falling edge, then take the rising edge.
    task automatic apply(input vec_t v, input string name);
        Run = v.run;
        DIN = v.din;
        exp_q.push_back(v);
        @(negedge Clock);
        compare(name);
        if (Done) done_cycles.push_back(cyc);
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (outs() !== 25'd0) begin
            failures++;
            $display("FAIL %s: outputs=%b required all zero", name, outs());
        end
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("%s[%0d]", name, i));
        end
        tbl.delete();
    endtask

    logic [2:0]  alu_exp [5];
    logic [3:0]  op;
    logic [15:0] ins;

    initial begin
        alu_exp = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
        Resetn = 1'b0;
        Run    = 1'b1;
        DIN    = 16'h2280;
        #12;
        check_zero("reset_hold_run1");
        @(posedge Clock);
        #1;
        Run    = 1'b0;
        Resetn = 1'b1;

        // Idle with Run low.
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        // mvi R2, #5
        tbl.push_back(mk(1, 16'h1400, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        tbl.push_back(mk(0, 16'h0005, 0, 8'h04, 0, 0, 1, 0, 0, 3'b000, 1));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        // add R1, R2
        tbl.push_back(mk(1, 16'h2280, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 8'h02, 0, 0, 1, 0, 3'b000, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 8'h04, 0, 0, 0, 1, 3'b000, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 8'h02, 0, 1, 0, 0, 0, 3'b000, 1));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        // add R2, R2
        tbl.push_back(mk(1, 16'h2480, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 8'h04, 0, 0, 1, 0, 3'b000, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 8'h04, 0, 0, 0, 1, 3'b000, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 8'h04, 0, 1, 0, 0, 0, 3'b000, 1));
        // illegal
        tbl.push_back(mk(1, 16'hF000, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        // mv R3, R3
        tbl.push_back(mk(1, 16'h06C0, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 8'h08, 8'h08, 0, 0, 0, 0, 3'b000, 1));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        run_table("basic");

        // sub..srl R1, R2: only the T2 ALU code differs.
        for (int k = 0; k < 5; k++) begin
            op  = 4'(k + 3);
            ins = {op, 3'd1, 3'd2, 6'h15};
            tbl.push_back(mk(1, ins, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0));
            tbl.push_back(mk(0, 16'h0000, 0, 0, 8'h02, 0, 0, 1, 0, 3'b000, 0));
            tbl.push_back(mk(0, 16'h0000, 0, 0, 8'h04, 0, 0, 0, 1, alu_exp[k], 0));
            tbl.push_back(mk(0, 16'h0000, 0, 8'h02, 0, 1, 0, 0, 0, 3'b000, 1));
        end
        run_table("aluops");

        // Reset asserted during T2 of an add abandons it.
        apply(mk(1, 16'h2280, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0), "rst_t0");
        apply(mk(0, 16'h0000, 0, 0, 8'h02, 0, 0, 1, 0, 3'b000, 0), "rst_t1");
        Run = 1'b0;
        exp_q.push_back(mk(0, 16'h0000, 0, 0, 8'h04, 0, 0, 0, 1, 3'b000, 0));
        @(negedge Clock);
        compare("rst_t2");
        #2;
        Resetn = 1'b0;
        #1;
        check_zero("rst_async");
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        run_table("after_rst");

        // Run held high: mv R0,R1 / sub R4,R5 / mv R7,R6 back to back; DIN noise mid-instruction.
        done_cycles.delete();
        cyc = 1;
        tbl.push_back(mk(1, 16'h0040, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        tbl.push_back(mk(1, 16'hF000, 0, 8'h01, 8'h02, 0, 0, 0, 0, 3'b000, 1));
        tbl.push_back(mk(1, 16'h3940, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        tbl.push_back(mk(1, 16'h0000, 0, 0, 8'h10, 0, 0, 1, 0, 3'b000, 0));
        tbl.push_back(mk(1, 16'hFFFF, 0, 0, 8'h20, 0, 0, 0, 1, 3'b001, 0));
        tbl.push_back(mk(1, 16'h1234, 0, 8'h10, 0, 1, 0, 0, 0, 3'b000, 1));
        tbl.push_back(mk(1, 16'h0F80, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 8'h80, 8'h40, 0, 0, 0, 0, 3'b000, 1));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        run_table("b2b");
        checks++;
        if (done_cycles.size() != 3 || done_cycles[0] != 2 || done_cycles[1] != 6 ||
            done_cycles[2] != 8) begin
            failures++;
            $display("FAIL b2b_done_cycles: got %p required '{2, 6, 8}", done_cycles);
        end

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
